// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer encodings, arbiter state enum and index-width helper.
// Pure declarations; no latency or flow-control behaviour of its own.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ARB_PARK = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_LOCK = 2'd2
  } arb_state_t;

  function automatic int HMASTER_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration signal bundle between bus masters and the arbiter.
// master = requester side, slave = arbiter side.
interface ahb_arbiter_if
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) ();

  localparam int MW = HMASTER_W(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic                   Hready;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [MW-1:0]          Hmaster;
  logic                   Hmastlock;

  modport master (
    output Hbusreq, Hlock, Htrans, Hready,
    input  Hgrant, Hmaster, Hmastlock
  );

  modport slave (
    input  Hbusreq, Hlock, Htrans, Hready,
    output Hgrant, Hmaster, Hmastlock
  );

endinterface

// File: rtl/ahb_rr_pick.sv
// Rotate-priority encoder: first requester at or after i_start, wrapping; purely combinational.
// No storage, no backpressure.
module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  localparam int IW          = HMASTER_W(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IW-1:0]          i_start,
  output logic [IW-1:0]          o_idx,
  output logic                   o_any
);

  logic [NUM_MASTERS-1:0] w_rot;
  logic [IW-1:0]          w_off;
  logic [IW:0]            w_sum;

  // Doubling the vector turns the wrap-around search into a plain right shift.
  assign w_rot = NUM_MASTERS'({i_req, i_req} >> i_start);

  always_comb begin
    w_off = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (w_rot[k[IW-1:0]]) w_off = k[IW-1:0];
    end
  end

  assign w_sum = {1'b0, i_start} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IW+1)'(NUM_MASTERS)) ? IW'(w_sum - (IW+1)'(NUM_MASTERS))
                                                 : w_sum[IW-1:0];
  assign o_any = |i_req;

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with lock, tenure cap and parking; grant 1 Hready edge after request.
// Hready=0 or a BUSY/SEQ beat freezes the grant; Hready=0 freezes all state.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic         Hclk,
  input  logic         Hresetn,
  ahb_arbiter_if.slave bus
);

  localparam int                     IW        = HMASTER_W(NUM_MASTERS);
  localparam int                     HW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [IW-1:0]          DEF_IDX   = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t             r_state, w_state_nxt;
  logic [IW-1:0]          r_owner, w_owner_nxt;
  logic [HW-1:0]          r_hold, w_hold_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]          r_hmaster, w_hmaster_nxt;
  logic                   r_mastlock, w_mastlock_nxt;

  logic          w_owner_req, w_owner_lock, w_others, w_defer, w_keep, w_any;
  logic [IW-1:0] w_start, w_win;

  assign w_owner_req  = bus.Hbusreq[r_owner];
  assign w_owner_lock = w_owner_req & bus.Hlock[r_owner];
  assign w_others     = |(bus.Hbusreq & ~r_grant);
  assign w_defer      = (bus.Htrans == HTRANS_BUSY) || (bus.Htrans == HTRANS_SEQ);
  assign w_keep       = w_owner_req && (w_owner_lock || (MAX_HOLD == 0) ||
                                        (int'(r_hold) + 1 < MAX_HOLD) || !w_others);
  assign w_start      = (r_owner == IW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;

  ahb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .i_req   (bus.Hbusreq),
    .i_start (w_start),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state    <= ARB_PARK;
      r_owner    <= DEF_IDX;
      r_hold     <= '0;
      r_grant    <= DEF_GRANT;
      r_hmaster  <= DEF_IDX;
      r_mastlock <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_hold     <= w_hold_nxt;
      r_grant    <= w_grant_nxt;
      r_hmaster  <= w_hmaster_nxt;
      r_mastlock <= w_mastlock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    if (bus.Hready && !w_defer) begin
      if (w_keep) begin
        w_state_nxt = w_owner_lock ? ARB_LOCK : ARB_OWN;
        // Tenure only accumulates across consecutive unlocked edges of the same owner.
        if (r_state == ARB_OWN && !w_owner_lock) begin
          if (int'(r_hold) < MAX_HOLD) w_hold_nxt = r_hold + 1'b1;
        end else begin
          w_hold_nxt = '0;
        end
      end else if (w_any) begin
        w_owner_nxt = w_win;
        w_state_nxt = bus.Hlock[w_win] ? ARB_LOCK : ARB_OWN;
        w_hold_nxt  = '0;
      end else begin
        w_owner_nxt = DEF_IDX;
        w_state_nxt = ARB_PARK;
        w_hold_nxt  = '0;
      end
    end
  end

  always_comb begin
    w_grant_nxt              = '0;
    w_grant_nxt[w_owner_nxt] = 1'b1;
    w_hmaster_nxt            = r_hmaster;
    w_mastlock_nxt           = r_mastlock;
    if (bus.Hready) begin
      w_hmaster_nxt  = r_owner;
      w_mastlock_nxt = w_owner_lock;
    end
  end

  assign bus.Hgrant    = r_grant;
  assign bus.Hmaster   = r_hmaster;
  assign bus.Hmastlock = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter (4 masters, default 0, MAX_HOLD=2).
// Driver queues hand-computed post-edge outputs; monitor checks them 1 ns after each edge.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  typedef struct {
    logic [3:0] g;
    logic [1:0] hm;
    logic       ml;
    string      nm;
  } exp_t;

  logic Hclk = 1'b0;
  logic Hresetn = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0),
    .MAX_HOLD       (2)
  ) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, req);
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] g, input logic [1:0] hm, input logic ml);
    chk({nm, ".Hgrant"}, 32'(bus.Hgrant), 32'(g));
    chk({nm, ".Hmaster"}, 32'(bus.Hmaster), 32'(hm));
    chk({nm, ".Hmastlock"}, 32'(bus.Hmastlock), 32'(ml));
  endtask

  // Apply inputs, queue what the outputs must be after the coming edge, then move past it.
  task automatic step(input logic [3:0] br, input logic [3:0] lk, input logic [1:0] tr,
                      input logic rdy, input logic [3:0] eg, input logic [1:0] ehm,
                      input logic eml, input string nm);
    exp_t e;
    bus.Hbusreq = br;
    bus.Hlock   = lk;
    bus.Htrans  = tr;
    bus.Hready  = rdy;
    e.g = eg; e.hm = ehm; e.ml = eml; e.nm = nm;
    exp_q.push_back(e);
    @(posedge Hclk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge Hclk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk_outs(e.nm, e.g, e.hm, e.ml);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.Hbusreq = 4'b0000;
    bus.Hlock   = 4'b0000;
    bus.Htrans  = HTRANS_IDLE;
    bus.Hready  = 1'b1;
    #1 Hresetn = 1'b0;
    #1 chk_outs("rst_async", 4'b0001, 2'd0, 1'b0);
    #10 Hresetn = 1'b1;
    @(posedge Hclk);
    #2;

    // Idle: parked on master 0
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, "idle");

    // Round robin with a tenure cap of two edges
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0, "rr1");
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b0, "rr2");
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd1, 1'b0, "rr3");
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd2, 1'b0, "rr4");
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd2, 1'b0, "rr5");
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd3, 1'b0, "rr6");
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd3, 1'b0, "rr7");
    step(4'b1110, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b0, "rr8");

    // Master 1 locks while master 2 waits, well beyond the tenure cap
    step(4'b0110, 4'b0010, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b1, "lock_in");
    for (int i = 0; i < 40; i++) step(4'b0110, 4'b0010, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b1, "lock_hold");
    step(4'b0100, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd1, 1'b0, "lock_out");

    // Burst deferral: owner 2 drops its request mid-burst
    step(4'b0100, 4'b0000, HTRANS_SEQ, 1'b1, 4'b0100, 2'd2, 1'b0, "seq_own");
    step(4'b1000, 4'b0000, HTRANS_SEQ, 1'b1, 4'b0100, 2'd2, 1'b0, "seq_defer1");
    step(4'b1000, 4'b0000, HTRANS_BUSY, 1'b1, 4'b0100, 2'd2, 1'b0, "busy_defer");
    step(4'b1000, 4'b0000, HTRANS_IDLE, 1'b1, 4'b1000, 2'd2, 1'b0, "seq_handover");
    step(4'b0000, 4'b0000, HTRANS_SEQ, 1'b1, 4'b1000, 2'd3, 1'b0, "seq_defer2");
    step(4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 4'b0001, 2'd3, 1'b0, "seq_park");
    step(4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, "parked");

    // Hready low freezes everything, including the tenure count of master 3
    step(4'b1000, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd0, 1'b0, "m3_grant");
    step(4'b1000, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd3, 1'b0, "m3_keep");
    step(4'b1010, 4'b0000, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd3, 1'b0, "wait1");
    step(4'b0110, 4'b1000, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd3, 1'b0, "wait2");
    step(4'b1110, 4'b1000, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd3, 1'b0, "wait3");
    step(4'b0011, 4'b0000, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd3, 1'b0, "wait4");
    step(4'b1111, 4'b1111, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd3, 1'b0, "wait5");
    step(4'b1010, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd3, 1'b0, "wait_release");
    step(4'b1010, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b0, "wait_after");

    // Master 3 locked mid-burst, then async reset between edges
    step(4'b1000, 4'b1000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd1, 1'b0, "m3_lock");
    step(4'b1000, 4'b1000, HTRANS_SEQ, 1'b1, 4'b1000, 2'd3, 1'b1, "m3_burst1");
    step(4'b1000, 4'b1000, HTRANS_SEQ, 1'b1, 4'b1000, 2'd3, 1'b1, "m3_burst2");
    #1 Hresetn = 1'b0;
    #1 chk_outs("rst_mid", 4'b0001, 2'd0, 1'b0);
    bus.Hbusreq = 4'b0000;
    bus.Hlock   = 4'b0000;
    bus.Htrans  = HTRANS_IDLE;
    @(posedge Hclk);
    #2 chk_outs("rst_held", 4'b0001, 2'd0, 1'b0);
    Hresetn = 1'b1;
    step(4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, "post_rst_idle");
    step(4'b1000, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd0, 1'b0, "post_rst_req");
    step(4'b1000, 4'b0000, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd3, 1'b0, "post_rst_own");

    repeat (2) @(posedge Hclk);
    #2 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
